// File: rtl/fpu_cvt_pkg.sv
// rtl/fpu_cvt_pkg.sv - shared enums, flag indices and bias helper for the float->int converter
package fpu_cvt_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        ALIGN,
        ROUND,
        PACK,
        PUT_Z
    } cvt_state_e;

    localparam int FLAG_NV = 1;
    localparam int FLAG_NX = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_to_int_conv_if.sv
// rtl/float_to_int_conv_if.sv - operand/result stb-ack handshake bundle; output_flags exists only with FCVT_FLAGS_EN
interface float_to_int_conv_if #(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic [EXP_W+MAN_W:0] input_a;
    logic                 input_signed;
    logic [2:0]           input_rm;
    logic                 input_a_stb;
    logic                 input_a_ack;
    logic [INT_W-1:0]     output_z;
    logic                 output_z_stb;
    logic                 output_z_ack;
`ifdef FCVT_FLAGS_EN
    logic [1:0]           output_flags;

    modport slave (
        input  input_a, input_signed, input_rm, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb, output_flags
    );
    modport master (
        output input_a, input_signed, input_rm, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb, output_flags
    );
`else
    modport slave (
        input  input_a, input_signed, input_rm, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );
    modport master (
        output input_a, input_signed, input_rm, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );
`endif
endinterface

// File: rtl/fcvt_round_unit.sv
// rtl/fcvt_round_unit.sv - decides whether the truncated magnitude is incremented for the given rounding mode
module fcvt_round_unit
    import fpu_cvt_pkg::*;
(
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_sticky,
    input  logic       i_sign,
    input  logic [2:0] i_rm,
    output logic       o_inc
);

    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RNE:     o_inc = i_guard & (i_sticky | i_lsb);
            RDN:     o_inc = i_sign & (i_guard | i_sticky);
            RUP:     o_inc = ~i_sign & (i_guard | i_sticky);
            RMM:     o_inc = i_guard;
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/float_to_int_conv.sv
// rtl/float_to_int_conv.sv - multi-cycle IEEE-754 float to signed/unsigned integer converter
// Optional {NV,NX} output_flags port under FCVT_FLAGS_EN.
module float_to_int_conv
    import fpu_cvt_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    float_to_int_conv_if.slave  bus
);

    localparam int FW = INT_W + MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'(bias(EXP_W));
    localparam logic signed [EW-1:0] E_OVF = EW'(INT_W);
    localparam logic signed [EW-1:0] E_MIN = EW'(-2);
    localparam logic [INT_W:0]       SMAX  = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0]       SNEG  = {2'b01, {(INT_W-1){1'b0}}};

    cvt_state_e r_state, w_next;

    logic [EXP_W+MAN_W:0]  r_a;
    logic                  r_signed;
    logic [2:0]            r_rm;
    logic                  r_sign, r_nan, r_inf;
    logic [MAN_W:0]        r_sig;
    logic signed [EW-1:0]  r_e_unb;
    logic [INT_W-1:0]      r_mag;
    logic                  r_guard, r_sticky, r_ovf;
    logic [INT_W:0]        r_mag_rnd;
    logic [INT_W-1:0]      r_z;

    logic [EXP_W-1:0]      w_exp, w_exp_eff;
    logic [MAN_W-1:0]      w_man;
    logic                  w_exp_max, w_exp_zero;
    logic signed [EW-1:0]  w_e_unb;
    logic [EW-1:0]         w_sh;
    logic [FW-1:0]         w_frame;
    logic [INT_W-1:0]      w_int;
    logic                  w_g, w_s, w_ovf, w_inc;
    logic [INT_W:0]        w_mag_rnd;
    logic                  w_range_nv, w_nv, w_sat_neg;
    logic [INT_W-1:0]      w_sat, w_z_pack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= GET_A;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            GET_A:   if (bus.input_a_stb) w_next = UNPACK;
            UNPACK:  w_next = ALIGN;
            ALIGN:   w_next = ROUND;
            ROUND:   w_next = PACK;
            PACK:    w_next = PUT_Z;
            PUT_Z:   if (bus.output_z_ack) w_next = GET_A;
            default: w_next = GET_A;
        endcase
    end

    // Subnormals share the minimum normal exponent; their hidden bit is cleared instead.
    assign w_exp      = r_a[EXP_W+MAN_W-1:MAN_W];
    assign w_man      = r_a[MAN_W-1:0];
    assign w_exp_max  = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_exp_eff  = w_exp_zero ? EXP_W'(1) : w_exp;
    assign w_e_unb    = $signed({2'b00, w_exp_eff}) - BIAS;

    // Frame holds the integer part above a guard bit and MAN_W+1 sticky bits.
    always_comb begin
        w_frame = '0;
        w_int   = '0;
        w_g     = 1'b0;
        w_s     = 1'b0;
        w_ovf   = 1'b0;
        w_sh    = r_e_unb - E_MIN;
        if (r_nan || r_inf || (r_e_unb >= E_OVF)) begin
            w_ovf = 1'b1;
        end else if (r_e_unb < E_MIN) begin
            w_s = |r_sig;
        end else begin
            w_frame = FW'(r_sig) << w_sh;
            w_int   = w_frame[FW-1:MAN_W+2];
            w_g     = w_frame[MAN_W+1];
            w_s     = |w_frame[MAN_W:0];
        end
    end

    fcvt_round_unit u_round (
        .i_lsb    (r_mag[0]),
        .i_guard  (r_guard),
        .i_sticky (r_sticky),
        .i_sign   (r_sign),
        .i_rm     (r_rm),
        .o_inc    (w_inc)
    );

    assign w_mag_rnd = {1'b0, r_mag} + (INT_W+1)'(w_inc);

    always_comb begin
        w_range_nv = 1'b0;
        if (r_signed) w_range_nv = r_sign ? (r_mag_rnd > SNEG) : (r_mag_rnd > SMAX);
        else          w_range_nv = r_sign ? (r_mag_rnd != '0) : r_mag_rnd[INT_W];
        w_nv      = r_ovf | w_range_nv;
        w_sat_neg = r_sign & ~r_nan;
        if (r_signed) w_sat = w_sat_neg ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        else          w_sat = w_sat_neg ? '0 : '1;
        w_z_pack = w_nv ? w_sat : (r_sign ? -r_mag_rnd[INT_W-1:0] : r_mag_rnd[INT_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0; r_signed <= 1'b0; r_rm <= '0;
            r_sign <= 1'b0; r_nan <= 1'b0; r_inf <= 1'b0; r_sig <= '0; r_e_unb <= '0;
            r_mag <= '0; r_guard <= 1'b0; r_sticky <= 1'b0; r_ovf <= 1'b0;
            r_mag_rnd <= '0; r_z <= '0;
        end else begin
            case (r_state)
                GET_A: if (bus.input_a_stb) begin
                    r_a      <= bus.input_a;
                    r_signed <= bus.input_signed;
                    r_rm     <= bus.input_rm;
                end
                UNPACK: begin
                    r_sign  <= r_a[EXP_W+MAN_W];
                    r_sig   <= {~w_exp_zero, w_man};
                    r_e_unb <= w_e_unb;
                    r_nan   <= w_exp_max & (|w_man);
                    r_inf   <= w_exp_max & ~(|w_man);
                end
                ALIGN: begin
                    r_mag    <= w_int;
                    r_guard  <= w_g;
                    r_sticky <= w_s;
                    r_ovf    <= w_ovf;
                end
                ROUND:   r_mag_rnd <= w_mag_rnd;
                PACK:    r_z <= w_z_pack;
                default: ;
            endcase
        end
    end

    assign bus.input_a_ack  = (r_state == GET_A);
    assign bus.output_z_stb = (r_state == PUT_Z);
    assign bus.output_z     = r_z;

`ifdef FCVT_FLAGS_EN
    logic       r_inexact;
    logic [1:0] r_flags, w_flags;

    always_comb begin
        w_flags          = '0;
        w_flags[FLAG_NV] = w_nv;
        w_flags[FLAG_NX] = r_inexact & ~w_nv;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inexact <= 1'b0;
            r_flags   <= '0;
        end else begin
            if (r_state == ROUND) r_inexact <= r_guard | r_sticky;
            if (r_state == PACK)  r_flags   <= w_flags;
        end
    end

    assign bus.output_flags = r_flags;
`endif

endmodule

// File: tb/tb_float_to_int_conv.sv
// tb/tb_float_to_int_conv.sv - scoreboard bench: directed spec cases plus random operands against an arithmetic model
`timescale 1ns/1ps
module tb_float_to_int_conv;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    float_to_int_conv_if #(.INT_W(32), .EXP_W(8), .MAN_W(23)) bus ();

    float_to_int_conv #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] z;
        logic [1:0]  flags;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic        sg;
        logic [2:0]  rm;
        logic [31:0] z;
        logic [1:0]  flags;
        logic        lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Exact rational reference: value = sig * 2^(e-23), rounded by comparing the remainder to one half.
    function automatic exp_t ref_conv(input logic [31:0] a, input bit sg, input logic [2:0] rm);
        exp_t   r;
        bit     neg, exact, tie, above, up;
        int     ex, e, k;
        longint sig, mag, v, den, rem, lo, hi;
        neg = a[31];
        ex  = int'(a[30:23]);
        lo  = sg ? -(64'sd1 <<< 31) : 64'sd0;
        hi  = sg ? (64'sd1 <<< 31) - 1 : (64'sd1 <<< 32) - 1;
        if (ex == 255) begin
            r.flags = 2'b10;
            r.z     = ((a[22:0] != 0) || !neg) ? hi[31:0] : lo[31:0];
            return r;
        end
        sig = (ex == 0) ? longint'(a[22:0]) : longint'(a[22:0]) + (64'sd1 <<< 23);
        e   = (ex == 0) ? -126 : ex - 127;
        if (e >= 40) begin
            r.flags = 2'b10;
            r.z     = neg ? lo[31:0] : hi[31:0];
            return r;
        end
        k = 23 - e;
        tie = 1'b0; above = 1'b0;
        if (k <= 0) begin
            mag = sig <<< (-k); exact = 1'b1;
        end else if (k >= 60) begin
            mag = 0; exact = (sig == 0);
        end else begin
            den   = 64'sd1 <<< k;
            mag   = sig / den;
            rem   = sig % den;
            exact = (rem == 0);
            tie   = (2 * rem == den);
            above = (2 * rem > den);
        end
        case (rm)
            3'd0:    up = above | (tie & mag[0]);
            3'd2:    up = neg & !exact;
            3'd3:    up = !neg & !exact;
            3'd4:    up = above | tie;
            default: up = 1'b0;
        endcase
        mag = mag + (up ? 64'sd1 : 64'sd0);
        v   = neg ? -mag : mag;
        if (v > hi) begin
            r.z = hi[31:0]; r.flags = 2'b10;
        end else if (v < lo) begin
            r.z = lo[31:0]; r.flags = 2'b10;
        end else begin
            r.z = v[31:0];  r.flags = {1'b0, !exact};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.output_z_stb && bus.output_z_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", bus.output_z);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_z", {32'h0, bus.output_z}, {32'h0, mon_e.z});
`ifdef FCVT_FLAGS_EN
                check("result_flags", {62'h0, bus.output_flags}, {62'h0, mon_e.flags});
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] a, input bit sg, input logic [2:0] rm,
                        input bit push, input exp_t e, output int waits);
        waits = 0;
        bus.input_a      = a;
        bus.input_signed = sg;
        bus.input_rm     = rm;
        bus.input_a_stb  = 1'b1;
        while (!bus.input_a_ack && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.input_a_ack) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ack0 required=ack1");
            bus.input_a_stb = 1'b0;
        end else begin
            if (push) sb_q.push_back(e);
            @(posedge clk);
            #1 bus.input_a_stb = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_latency();
        check("lat_c0", {63'h0, bus.output_z_stb}, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("lat_c%0d", i), {63'h0, bus.output_z_stb}, {63'h0, (i == 4)});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[] = '{
        '{32'h40000000, 1'b1, 3'd1, 32'h00000002, 2'b00, 1'b1},
        '{32'hC0E00000, 1'b1, 3'd0, 32'hFFFFFFF9, 2'b00, 1'b0},
        '{32'hC0E00000, 1'b0, 3'd0, 32'h00000000, 2'b10, 1'b0},
        '{32'h3FC00000, 1'b1, 3'd0, 32'h00000002, 2'b01, 1'b0},
        '{32'h3FC00000, 1'b1, 3'd1, 32'h00000001, 2'b01, 1'b0},
        '{32'h40200000, 1'b1, 3'd0, 32'h00000002, 2'b01, 1'b0},
        '{32'h40200000, 1'b1, 3'd4, 32'h00000003, 2'b01, 1'b0},
        '{32'h40200000, 1'b1, 3'd3, 32'h00000003, 2'b01, 1'b0},
        '{32'hC0200000, 1'b1, 3'd2, 32'hFFFFFFFD, 2'b01, 1'b0},
        '{32'h7FC00000, 1'b1, 3'd1, 32'h7FFFFFFF, 2'b10, 1'b1},
        '{32'h4F000000, 1'b1, 3'd1, 32'h7FFFFFFF, 2'b10, 1'b0},
        '{32'h4F000000, 1'b0, 3'd1, 32'h80000000, 2'b00, 1'b0},
        '{32'hFF800000, 1'b1, 3'd1, 32'h80000000, 2'b10, 1'b0},
        '{32'h00000000, 1'b1, 3'd0, 32'h00000000, 2'b00, 1'b0},
        '{32'h80000000, 1'b0, 3'd0, 32'h00000000, 2'b00, 1'b0},
        '{32'h00000001, 1'b1, 3'd3, 32'h00000001, 2'b01, 1'b0},
        '{32'hCF000000, 1'b1, 3'd1, 32'h80000000, 2'b00, 1'b0},
        '{32'h4F800000, 1'b0, 3'd1, 32'hFFFFFFFF, 2'b10, 1'b0},
        '{32'hBF000000, 1'b0, 3'd2, 32'h00000000, 2'b10, 1'b0},
        '{32'hBF000000, 1'b0, 3'd0, 32'h00000000, 2'b01, 1'b0},
        '{32'h3FC00000, 1'b1, 3'd7, 32'h00000001, 2'b01, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        exp_t        e;
        logic [31:0] a, hold_z;
        logic [1:0]  hold_f;
        logic [7:0]  ex;
        logic [22:0] man;
        bit          sg;
        logic [2:0]  rm;

        bus.input_a      = '0;
        bus.input_signed = 1'b0;
        bus.input_rm     = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b1;
        hold_f           = '0;
        repeat (3) @(negedge clk);
        check("reset_stb", {63'h0, bus.output_z_stb}, 64'h0);
        check("reset_z", {32'h0, bus.output_z}, 64'h0);
        check("reset_ack", {63'h0, bus.input_a_ack}, 64'h1);
`ifdef FCVT_FLAGS_EN
        check("reset_flags", {62'h0, bus.output_flags}, 64'h0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_ack", {63'h0, bus.input_a_ack}, 64'h1);

        foreach (vecs[i]) begin
            e.z = vecs[i].z;
            e.flags = vecs[i].flags;
            send(vecs[i].a, vecs[i].sg, vecs[i].rm, 1'b1, e, w);
            if (vecs[i].lat) check_latency();
        end

        for (int n = 0; n < 200; n++) begin
            ex  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(123, 161));
            man = 23'($urandom);
            if ($urandom_range(0, 2) == 0) man[19:0] = '0;
            a  = {1'($urandom_range(0, 1)), ex, man};
            sg = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            send(a, sg, rm, 1'b1, ref_conv(a, sg, rm), w);
        end
        drain();

        // Backpressure: result must hold and no new operand may be accepted.
        @(posedge clk);
        #1 bus.output_z_ack = 1'b0;
        @(negedge clk);
        e.z = 32'h3; e.flags = 2'b01;
        send(32'h40200000, 1'b1, 3'd4, 1'b1, e, w);
        w = 0;
        while (!bus.output_z_stb && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_stb", {63'h0, bus.output_z_stb}, 64'h1);
        hold_z = bus.output_z;
`ifdef FCVT_FLAGS_EN
        hold_f = bus.output_flags;
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_z_stable", {32'h0, bus.output_z}, {32'h0, hold_z});
            check("bp_in_ack", {63'h0, bus.input_a_ack}, 64'h0);
`ifdef FCVT_FLAGS_EN
            check("bp_flags_stable", {62'h0, bus.output_flags}, {62'h0, hold_f});
`endif
        end
        @(posedge clk);
        #1 bus.output_z_ack = 1'b1;
        @(negedge clk);
        e.z = 32'h5; e.flags = 2'b00;
        send(32'h40A00000, 1'b1, 3'd1, 1'b1, e, w);
        check("bp_accept_wait", {63'h0, (w <= 1)}, 64'h1);
        drain();

        // Reset in ALIGN clears the result that was left at 5.
        send(32'h40000000, 1'b1, 3'd1, 1'b0, e, w);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_align_stb", {63'h0, bus.output_z_stb}, 64'h0);
        check("rst_align_z", {32'h0, bus.output_z}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ack", {63'h0, bus.input_a_ack}, 64'h1);
        e.z = 32'h0; e.flags = 2'b01;
        send(32'hBECCCCCD, 1'b0, 3'd1, 1'b1, e, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
